hazard_unit_mc: RTL

- Next-generation hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Keeps M/W operand forwarding, load-use stalling and branch flushing.
- Adds: parametrised register-address width; a multi-cycle execute FSM for MUL/DIV-class ops that holds E for MC_LAT cycles; variable-latency data-memory wait handling; a saturating stall-cycle performance counter.
- Sits beside the datapath and drives all pipeline-register enable/clear signals.

---
 rtl/hazard_unit_mc_if.sv | 64 ++++++
 rtl/hazard_unit_mc.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc_if.sv
// ============================================================================
// Module      : hazard_unit_mc_if
// Description : Datapath <-> hazard unit signal bundle. The datapath (master)
//               supplies register addresses and pipeline status; the hazard
//               unit (slave) returns forwarding selects and stall/flush lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_unit_mc_if #(
  parameter int ADDR_W = 5,
  parameter int PERF_W = 16
);
  logic [ADDR_W-1:0] rs1_addr_d;
  logic [ADDR_W-1:0] rs2_addr_d;
  logic [ADDR_W-1:0] rs1_addr_e;
  logic [ADDR_W-1:0] rs2_addr_e;
  logic [ADDR_W-1:0] write_addr_e;
  logic [ADDR_W-1:0] write_addr_m;
  logic [ADDR_W-1:0] write_addr_w;
  logic              reg_write_m;
  logic              reg_write_w;
  logic [1:0]        result_src_e;
  logic              pc_src_e;
  logic              mc_op_e;
  logic              mem_req_m;
  logic              mem_ready_m;
  logic [1:0]        forward_srcA_e;
  logic [1:0]        forward_srcB_e;
  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              stall_m;
  logic              flush_d;
  logic              flush_e;
  logic              flush_m;
  logic              flush_w;
  logic              mc_busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e,
    output write_addr_e, write_addr_m, write_addr_w,
    output reg_write_m, reg_write_w, result_src_e, pc_src_e,
    output mc_op_e, mem_req_m, mem_ready_m,
    input  forward_srcA_e, forward_srcB_e,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_m, flush_w,
    input  mc_busy, stall_cycles
  );

  modport slave (
    input  rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e,
    input  write_addr_e, write_addr_m, write_addr_w,
    input  reg_write_m, reg_write_w, result_src_e, pc_src_e,
    input  mc_op_e, mem_req_m, mem_ready_m,
    output forward_srcA_e, forward_srcB_e,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_m, flush_w,
    output mc_busy, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_unit_mc.sv
// ============================================================================
// Module      : hazard_unit_mc
// Description : 5-stage pipeline hazard unit: M/W forwarding, load-use stall,
//               branch flush, multi-cycle execute hold, memory-wait freeze and
//               a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit_mc #(
  parameter int         ADDR_W   = 5,
  parameter int         MC_LAT   = 4,
  parameter int         CNT_MC_W = 4,
  parameter logic [1:0] LOAD_SRC = 2'b01,
  parameter int         PERF_W   = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  hazard_unit_mc_if.slave  hz
);

  localparam logic                ST_IDLE   = 1'b0;
  localparam logic                ST_BUSY   = 1'b1;
  localparam logic [CNT_MC_W-1:0] CNT_START = CNT_MC_W'(MC_LAT - 2);
  localparam logic [ADDR_W-1:0]   REG_ZERO  = '0;

  logic                state_q, state_d;
  logic [CNT_MC_W-1:0] cnt_q, cnt_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic [1:0] fwd_a, fwd_b;
  logic       mem_wait, mc_stall, lw_hit, lw_stall;
  logic       stall_e_raw, stall_f_raw, flush_d_raw, flush_e_raw;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.reg_write_m && hz.rs1_addr_e != REG_ZERO && hz.rs1_addr_e == hz.write_addr_m)
      fwd_a = 2'b10;
    else if (hz.reg_write_w && hz.rs1_addr_e != REG_ZERO && hz.rs1_addr_e == hz.write_addr_w)
      fwd_a = 2'b01;
    if (hz.reg_write_m && hz.rs2_addr_e != REG_ZERO && hz.rs2_addr_e == hz.write_addr_m)
      fwd_b = 2'b10;
    else if (hz.reg_write_w && hz.rs2_addr_e != REG_ZERO && hz.rs2_addr_e == hz.write_addr_w)
      fwd_b = 2'b01;
  end

  assign mem_wait = hz.mem_req_m & ~hz.mem_ready_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // A memory wait freezes the FSM entirely; the release cycle ignores mc_op_e.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      case (state_q)
        ST_IDLE: begin
          if (hz.mc_op_e) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_START;
          end
        end
        default: begin
          if (cnt_q != '0) cnt_d   = cnt_q - CNT_MC_W'(1);
          else             state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mc_stall = 1'b0;
    if (!mem_wait) begin
      case (state_q)
        ST_IDLE: mc_stall = hz.mc_op_e;
        default: mc_stall = (cnt_q != '0);
      endcase
    end
  end

  assign stall_e_raw = mem_wait | mc_stall;
  assign lw_hit      = (hz.result_src_e == LOAD_SRC) && (hz.write_addr_e != REG_ZERO) &&
                       (hz.rs1_addr_d == hz.write_addr_e || hz.rs2_addr_d == hz.write_addr_e);
  // The D instruction is already held while E stalls, so load-use yields.
  assign lw_stall    = lw_hit & ~stall_e_raw;
  assign stall_f_raw = stall_e_raw | lw_stall;
  assign flush_d_raw = hz.pc_src_e & ~stall_e_raw;
  assign flush_e_raw = (lw_stall | hz.pc_src_e) & ~stall_e_raw;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_f_raw && stall_cycles_q != {PERF_W{1'b1}})
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  assign hz.forward_srcA_e = fwd_a;
  assign hz.forward_srcB_e = fwd_b;
  assign hz.stall_f        = ~reset & stall_f_raw;
  assign hz.stall_d        = ~reset & stall_f_raw;
  assign hz.stall_e        = ~reset & stall_e_raw;
  assign hz.stall_m        = ~reset & mem_wait;
  assign hz.flush_d        = ~reset & flush_d_raw;
  assign hz.flush_e        = ~reset & flush_e_raw;
  assign hz.flush_m        = ~reset & mc_stall;
  assign hz.flush_w        = ~reset & mem_wait;
  assign hz.mc_busy        = (state_q == ST_BUSY);
  assign hz.stall_cycles   = stall_cycles_q;

endmodule

`default_nettype wire
